nv_ram_fifo_ctrl_16x256: RTL and testbench



---
 rtl/nv_ram_fifo_ctrl_16x256.sv | 126 ++++++++++++
 tb/tb_nv_ram_fifo_ctrl_16x256.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_16x256.sv
// nv_ram_fifo_ctrl_16x256: valid/ready FIFO controller around an external
// 16x256 two-port RAM that has a registered read address (latched on re) and
// an output register loaded on ore. The read side is a two-stage pipeline
// (s1 = address register, s2 = output register) with full-rate back-pressure.
// Optional macro NV_RAM_FIFO_CTRL_OCC_EN adds the occ/occ_peak outputs.
module nv_ram_fifo_ctrl_16x256 #(
  parameter int DW = 256,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic          idle
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
  ,
  output logic [AW:0]   occ,
  output logic [AW:0]   occ_peak
`endif
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] iss_ptr_q, iss_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;   // written, not yet captured by ore
  logic [AW:0]   pend_cnt_q, pend_cnt_d; // written, not yet issued by re
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic          push, re, ore;

  // Handshake and pipeline-advance terms
  always_comb begin
    push = wr_pvld & wr_prdy;
    ore  = s1_vld_q & (~s2_vld_q | rd_prdy);
    re   = (pend_cnt_q != '0) & (~s1_vld_q | ore);
  end

  assign wr_prdy = (ram_cnt_q != DEPTH);
  assign ram_we  = push;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = re;
  assign ram_ra  = iss_ptr_q;
  assign ram_ore = ore;
  assign rd_pvld = s2_vld_q;
  assign rd_pd   = ram_dout;
  assign idle    = (ram_cnt_q == '0) & ~s2_vld_q;

  // Next-state: pointers, counters and pipeline valids; flush wins over all
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    iss_ptr_d  = iss_ptr_q + AW'(re);
    pend_cnt_d = pend_cnt_q + (AW+1)'(push) - (AW+1)'(re);
    // A slot is only freed once its word sits in the output register, so the
    // word addressed by a stalled s1 cannot be overwritten underneath it.
    ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(ore);
    s1_vld_d   = s1_vld_q;
    if (re)       s1_vld_d = 1'b1;
    else if (ore) s1_vld_d = 1'b0;
    s2_vld_d   = s2_vld_q;
    if (ore)          s2_vld_d = 1'b1;
    else if (rd_prdy) s2_vld_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      iss_ptr_d  = '0;
      pend_cnt_d = '0;
      ram_cnt_d  = '0;
      s1_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      iss_ptr_q  <= '0;
      pend_cnt_q <= '0;
      ram_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      iss_ptr_q  <= iss_ptr_d;
      pend_cnt_q <= pend_cnt_d;
      ram_cnt_q  <= ram_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
    end
  end

`ifdef NV_RAM_FIFO_CTRL_OCC_EN
  logic [AW:0] occ_peak_q, occ_peak_d;
  logic [AW:0] occ_nxt;

  assign occ      = ram_cnt_q + (AW+1)'(s2_vld_q);
  assign occ_peak = occ_peak_q;

  // Peak tracks next-cycle occupancy so it never lags occ
  always_comb begin
    occ_nxt    = ram_cnt_d + (AW+1)'(s2_vld_d);
    occ_peak_d = (occ_nxt > occ_peak_q) ? occ_nxt : occ_peak_q;
    if (flush) occ_peak_d = '0;
  end

  // Sticky peak register
  always_ff @(posedge clk) begin
    if (rst) occ_peak_q <= '0;
    else     occ_peak_q <= occ_peak_d;
  end
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_16x256.sv
// Bench for nv_ram_fifo_ctrl_16x256 with a behavioural model of the external
// two-port RAM. Writes accepted by the DUT are pushed to a scoreboard queue; a
// monitor pops and compares on every read handshake.
module tb_nv_ram_fifo_ctrl_16x256;
  localparam int DW = 256;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, wr_pvld, rd_prdy;
  logic [DW-1:0] wr_pd;
  logic          wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, idle;
  logic [DW-1:0] rd_pd, ram_di, ram_dout;
  logic [AW-1:0] ram_wa, ram_ra;
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
  logic [AW:0]   occ, occ_peak;
`endif

  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_16x256 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .idle(idle)
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
    , .occ(occ), .occ_peak(occ_peak)
`endif
  );

  // RAM model: registered read address, output register loaded on ore
  logic [DW-1:0] mem [16];
  logic [AW-1:0] ra_r;
  logic [DW-1:0] dout_r;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_r <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_r];
  end
  assign ram_dout = dout_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic [DW-1:0] q [$];
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", rd_pvld, 1);
        chk("hold_data", rd_pd, held_d);
      end
      if (rd_pvld && rd_prdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no output", rd_pd);
        end else begin
          chk("data", rd_pd, q.pop_front());
        end
      end
      if (wr_pvld && wr_prdy) begin
        q.push_back(wr_pd);
        chk("capacity", (q.size() <= 17), 1);
      end
      held_v = rd_pvld & ~rd_prdy;
      held_d = rd_pd;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, idle, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a5;
    int v;
    logic acc;
    a5 = {32{8'hA5}};
    rst = 1'b1; flush = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_wr_prdy", wr_prdy, 1);
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_ore", ram_ore, 0);

    // Single write latency
    cyc(); wr_pvld = 1'b1; wr_pd = a5; rd_prdy = 1'b1;
    @(negedge clk);
    chk("t0_ram_we", ram_we, 1);
    chk("t0_ram_wa", ram_wa, 0);
    chk("t0_ram_di", ram_di, a5);
    cyc(); wr_pvld = 1'b0;
    @(negedge clk);
    chk("t1_ram_re", ram_re, 1);
    chk("t1_ram_ra", ram_ra, 0);
    chk("t1_rd_pvld", rd_pvld, 0);
    @(negedge clk);
    chk("t2_ram_ore", ram_ore, 1);
    chk("t2_rd_pvld", rd_pvld, 0);
    @(negedge clk);
    chk("t3_rd_pvld", rd_pvld, 1);
    chk("t3_rd_pd", rd_pd, a5);
    @(negedge clk);
    chk("t4_idle", idle, 1);

    // Fill with reads stalled: 17 words accepted, then full
    cyc(); rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (v = 0; v < 17; v++) begin
      wr_pd = DW'(v);
      @(negedge clk);
      chk("fill_rdy", wr_prdy, 1);
      cyc();
    end
    wr_pd = DW'(17);
    @(negedge clk);
    chk("fill_full", wr_prdy, 0);
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
    chk("occ_full", occ, 17);
    chk("peak_full", occ_peak, 17);
`endif
    cyc();
    @(negedge clk);
    chk("fill_full_hold", wr_prdy, 0);
    cyc(); rd_prdy = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c == 0) chk("full_free_same_cycle", wr_prdy, 0);
      if (c == 1) chk("full_free_next_cycle", wr_prdy, 1);
      chk("drain_nogap", rd_pvld, 1);
      acc = wr_pvld & wr_prdy;
      cyc();
      if (acc) begin
        v++;
        if (v > 20) wr_pvld = 1'b0;
        else wr_pd = DW'(v);
      end
    end
    wait_idle("drain_idle");
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
    chk("occ_drained", occ, 0);
    chk("peak_drained", occ_peak, 17);
`endif

    // Streaming 100 words, wraps both pointers several times
    cyc(); wr_pvld = 1'b1; rd_prdy = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wr_pd = DW'(1000 + c);
      @(negedge clk);
      chk("stream_rdy", wr_prdy, 1);
      if (c >= 3) chk("stream_vld", rd_pvld, 1);
      cyc();
    end
    wr_pvld = 1'b0;
    wait_idle("stream_idle");

    // Random valid/ready traffic
    cyc();
    for (int c = 0; c < 400; c++) begin
      wr_pvld = ($urandom_range(0, 9) < 7);
      rd_prdy = ($urandom_range(0, 1) == 1);
      wr_pd   = {8{$urandom}};
      cyc();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    wait_idle("random_idle");

    // Flush with 10 stored and 2 in flight
    cyc(); rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wr_pd = DW'(32'h5000 + c);
      cyc();
    end
    wr_pvld = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_pvld", rd_pvld, 1);
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("flush_rd_pvld", rd_pvld, 0);
    chk("flush_idle", idle, 1);
    chk("flush_wr_prdy", wr_prdy, 1);
`ifdef NV_RAM_FIFO_CTRL_OCC_EN
    chk("flush_peak", occ_peak, 0);
    chk("flush_occ", occ, 0);
`endif
    cyc(); wr_pvld = 1'b1; wr_pd = DW'(1); rd_prdy = 1'b1;
    cyc(); wr_pvld = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!rd_pvld && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("flush_first_vld", rd_pvld, 1);
      chk("flush_first_data", rd_pd, 1);
    end
    wait_idle("flush_idle_end");
    chk("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
